cache_tag_lookup: RTL and testbench
===================================

Name: cache_tag_lookup

Overview:
Sequential set-associative cache tag controller and the successor to the combinational address splitter. It accepts an address and an operation over a valid/ready handshake, then splits the address into tag, index and byte_select. It looks the tag up in an internal tag/valid/dirty array, maintains true-LRU per set, and reports hit/miss, the selected way and any dirty eviction. It sits between the CPU-side request generator and the (future) data array/write-back logic.

Parameters:
instruction_size, 16, address width in bits
capacity, 10, log2 of total cache lines (sets*ways)
associativity, 8, ways per set (power of 2, >=2)
data_lines, 6, log2 of bytes per line (byte_select width)
Derived: W=$clog2(associativity); IB=capacity-W (index bits); TB=instruction_size-IB-data_lines (tag bits)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept (high only in IDLE)
req_addr  in  instruction_size  request address
req_op  in  2  00 read, 01 write, 10 invalidate, 11 flush-all
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  tag matched a valid way
resp_way  out  W  way hit or allocated
resp_evict  out  1  a valid dirty line was displaced or invalidated
resp_evict_tag  out  TB  tag of that displaced line
resp_tag  out  TB  addr[instruction_size-1 : IB+data_lines] of accepted request
resp_index  out  IB  addr[IB+data_lines-1 : data_lines]
resp_byte_select  out  data_lines  addr[data_lines-1:0]

Behaviour:
- Reset (async, reset_n=0): state IDLE; all valid/dirty=0; age[set][w]=w; all resp_* outputs=0; req_ready=1 once reset_n is high. Reset mid-operation aborts it: no resp_valid, array cleared.
- Handshake: accept at a rising edge where req_valid&&req_ready. Latch addr/op. No queueing; req_valid while busy is ignored and the master holds it.
- FSM: IDLE -(accept, op!=11)-> LOOKUP -> RESP -> IDLE. IDLE -(accept, op=11)-> FLUSH (2^IB cycles) -> RESP -> IDLE.
- Latency: lookup ops assert resp_valid in the 2nd cycle after the accept edge (one LOOKUP cycle). Flush asserts resp_valid 2^IB+1 cycles after accept. resp_valid lasts exactly 1 cycle. Other resp_* hold their values until the next response.
- LOOKUP: a hit means valid[w] && tag[w]==req tag. If more than one way matches (illegal), the lowest-numbered way wins.
- Victim on miss: lowest-numbered invalid way; otherwise the way with age==associativity-1.
- Read: hit -> hit=1, way=hit way, touch LRU. Miss -> install tag, valid=1, dirty=0, hit=0, way=victim, touch LRU.
- Write: as read, but dirty=1 on the hit or allocated way.
- Eviction: on a miss, evict=1 iff the victim was valid && dirty; evict_tag=old victim tag. Otherwise evict=0 and evict_tag=0.
- Invalidate: hit -> valid=0, dirty=0, hit=1, evict=old dirty, evict_tag=tag if evict; LRU unchanged. Miss -> no state change, hit=0, evict=0.
- Flush: clears valid/dirty of set 0..2^IB-1, one set per cycle ascending. Resets ages to age[w]=w. Response has hit=0, way=0, evict=0, and resp_tag/index/byte_select from the accepted address.
- LRU touch of way w with age a: every way with age<a increments, age[w]=0. Ages stay a permutation of 0..associativity-1.
- Array/LRU updates commit at the LOOKUP->RESP edge. A request accepted after RESP observes them.

Test Plan:
(Bench config: instruction_size=16, capacity=6, associativity=4, data_lines=4 -> IB=4, TB=8.)
1. Reset, read 0x1234 -> resp_valid 2nd cycle after accept, hit=0, way=0, evict=0, tag=0x12, index=0x3, byte_select=0x4. Repeat read -> hit=1, way=0.
2. Reads 0x1234,0x2234,0x3234,0x4234 -> misses ways 0,1,2,3. Read 0x1234 -> hit way0. Read 0x5234 -> miss, way=1, evict=0.
3. Reset, write 0xA050 (miss, way0, dirty). Read 0xB050,0xC050,0xD050 -> ways1-3. Read 0xE050 -> hit=0, way=0, evict=1, evict_tag=0xA0.
4. Write 0x1234, invalidate 0x1234 -> hit=1, evict=1, evict_tag=0x12. Invalidate 0x1234 again -> hit=0, evict=0. Read 0x1234 -> miss way0.
5. Populate sets 0x3 and 0x5, op=11 -> req_ready low 17 cycles, resp_valid at cycle 17 after accept with hit=0. req_valid pulses during flush are ignored. Then read 0x1234 -> miss way0.
6. Accept read 0x1234, drop reset_n during LOOKUP -> no resp_valid, outputs 0. After release, read 0x1234 -> hit=0.

Source files
------------

// File: rtl/cache_tag_lookup.sv
// cache_tag_lookup: set-associative tag controller with true-LRU per set.
// Accepts one request at a time, looks the tag up in one cycle, and
// reports hit/way/eviction on a one-cycle resp_valid strobe.
module cache_tag_lookup #(
   parameter  int instruction_size = 16,
   parameter  int capacity         = 10,
   parameter  int associativity    = 8,
   parameter  int data_lines       = 6,
   localparam int W    = $clog2(associativity),
   localparam int IB   = capacity - W,
   localparam int TB   = instruction_size - IB - data_lines,
   localparam int SETS = 1 << IB
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [instruction_size-1:0] req_addr,
   input  logic [1:0]                  req_op,
   output logic                        resp_valid,
   output logic                        resp_hit,
   output logic [W-1:0]                resp_way,
   output logic                        resp_evict,
   output logic [TB-1:0]               resp_evict_tag,
   output logic [TB-1:0]               resp_tag,
   output logic [IB-1:0]               resp_index,
   output logic [data_lines-1:0]       resp_byte_select
);

   typedef enum logic [1:0] {IDLE, LOOKUP, FLUSH, RESP} state_t;

   localparam logic [1:0] OP_INV   = 2'b10;
   localparam logic [1:0] OP_FLUSH = 2'b11;

   state_t                        state, state_nx;
   logic [instruction_size-1:0]   addr_q;
   logic [1:0]                    op_q;
   logic [IB-1:0]                 fidx;

   logic [TB-1:0]                 tags  [SETS][associativity];
   logic [W-1:0]                  age   [SETS][associativity];
   logic [associativity-1:0]      valid [SETS];
   logic [associativity-1:0]      dirty [SETS];

   logic [TB-1:0]                 req_tag;
   logic [IB-1:0]                 req_idx;
   logic [data_lines-1:0]         req_bs;

   logic                          hit, inv_found, miss_evict, flush_last;
   logic [W-1:0]                  hit_way, inv_way, lru_way, victim, tgt_way;

   assign req_tag    = addr_q[instruction_size-1 -: TB];
   assign req_idx    = addr_q[data_lines +: IB];
   assign req_bs     = addr_q[data_lines-1:0];
   assign req_ready  = (state == IDLE);
   assign flush_last = (fidx == IB'(SETS-1));
   // the victim of a miss is only ever dirty-valid when no invalid way exists
   assign miss_evict = !hit && valid[req_idx][victim] && dirty[req_idx][victim];

   // Tag compare and victim selection; descending scan so the lowest way wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      for (int w = associativity-1; w >= 0; w--) begin
         if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = W'(w);
         end
         if (!valid[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = W'(w);
         end
         if (age[req_idx][w] == W'(associativity-1)) lru_way = W'(w);
      end
      victim  = inv_found ? inv_way : lru_way;
      tgt_way = hit ? hit_way : victim;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid) state_nx = (req_op == OP_FLUSH) ? FLUSH : LOOKUP;
         LOOKUP:  state_nx = RESP;
         FLUSH:   if (flush_last) state_nx = RESP;
         default: state_nx = IDLE;
      endcase
   end

   // Tag/valid/dirty/age array; lookups commit on the LOOKUP->RESP edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
            for (int w = 0; w < associativity; w++) begin
               tags[s][w] <= '0;
               age[s][w]  <= W'(w);
            end
         end
      end else if (state == LOOKUP) begin
         if (op_q == OP_INV) begin
            if (hit) begin
               valid[req_idx][hit_way] <= 1'b0;
               dirty[req_idx][hit_way] <= 1'b0;
            end
         end else begin
            if (!hit) begin
               tags[req_idx][victim]  <= req_tag;
               valid[req_idx][victim] <= 1'b1;
               dirty[req_idx][victim] <= op_q[0];
            end else if (op_q[0]) begin
               dirty[req_idx][hit_way] <= 1'b1;
            end
            for (int w = 0; w < associativity; w++) begin
               if (W'(w) == tgt_way)
                  age[req_idx][w] <= '0;
               else if (age[req_idx][w] < age[req_idx][tgt_way])
                  age[req_idx][w] <= age[req_idx][w] + 1'b1;
            end
         end
      end else if (state == FLUSH) begin
         valid[fidx] <= '0;
         dirty[fidx] <= '0;
         for (int w = 0; w < associativity; w++) age[fidx][w] <= W'(w);
      end
   end

   // State, request latch, flush walker and registered response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         addr_q           <= '0;
         op_q             <= '0;
         fidx             <= '0;
         resp_valid       <= 1'b0;
         resp_hit         <= 1'b0;
         resp_way         <= '0;
         resp_evict       <= 1'b0;
         resp_evict_tag   <= '0;
         resp_tag         <= '0;
         resp_index       <= '0;
         resp_byte_select <= '0;
      end else begin
         state      <= state_nx;
         resp_valid <= 1'b0;
         if (state == IDLE && req_valid) begin
            addr_q <= req_addr;
            op_q   <= req_op;
            fidx   <= '0;
         end
         if (state == FLUSH) fidx <= fidx + 1'b1;
         if (state == LOOKUP || (state == FLUSH && flush_last)) begin
            resp_valid       <= 1'b1;
            resp_tag         <= req_tag;
            resp_index       <= req_idx;
            resp_byte_select <= req_bs;
         end
         if (state == LOOKUP) begin
            resp_hit <= hit;
            if (op_q == OP_INV) begin
               resp_way       <= hit ? hit_way : '0;
               resp_evict     <= hit && dirty[req_idx][hit_way];
               resp_evict_tag <= (hit && dirty[req_idx][hit_way]) ? tags[req_idx][hit_way] : '0;
            end else begin
               resp_way       <= tgt_way;
               resp_evict     <= miss_evict;
               resp_evict_tag <= miss_evict ? tags[req_idx][victim] : '0;
            end
         end else if (state == FLUSH && flush_last) begin
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup: 16-bit address, 16 sets x 4 ways,
// 16-byte lines (tag = addr[15:8], index = addr[7:4], byte = addr[3:0]).
module tb_cache_tag_lookup;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_addr = '0;
   logic [1:0]  req_op = '0;
   logic        resp_valid, resp_hit, resp_evict;
   logic [1:0]  resp_way;
   logic [7:0]  resp_evict_tag, resp_tag;
   logic [3:0]  resp_index, resp_byte_select;

   int total = 0;
   int passes = 0;
   int fails = 0;
   int lat;

   cache_tag_lookup #(
      .instruction_size(16), .capacity(6), .associativity(4), .data_lines(4)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_op(req_op),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
      .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
      .resp_tag(resp_tag), .resp_index(resp_index),
      .resp_byte_select(resp_byte_select)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      req_valid = 1'b0;
      reset_n   = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step();
   endtask

   // Accept one request and wait (bounded) for resp_valid; lat counts edges after accept.
   task automatic send(input logic [15:0] a, input logic [1:0] op);
      req_addr = a; req_op = op; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 100) begin
         step();
         lat++;
      end
   endtask

   task automatic lookup(input string name, input logic [15:0] a, input logic [1:0] op,
                         input logic hit, input logic [1:0] way,
                         input logic ev, input logic [7:0] evtag);
      send(a, op);
      chk({name, ".lat"}, lat, 1);
      chk({name, ".hit"}, resp_hit, hit);
      chk({name, ".way"}, resp_way, way);
      chk({name, ".evict"}, resp_evict, ev);
      chk({name, ".evict_tag"}, resp_evict_tag, evtag);
      step();
      chk({name, ".pulse_end"}, resp_valid, 1'b0);
      chk({name, ".ready"}, req_ready, 1'b1);
   endtask

   initial begin
      // 1: reset state, first miss, field split, repeat hit
      do_reset();
      chk("rst.valid", resp_valid, 1'b0);
      chk("rst.hit", resp_hit, 1'b0);
      chk("rst.way", resp_way, 2'd0);
      chk("rst.evict", resp_evict, 1'b0);
      chk("rst.tag", resp_tag, 8'h00);
      chk("rst.ready", req_ready, 1'b1);
      req_addr = 16'h1234; req_op = 2'b00; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("t1.cyc1_valid", resp_valid, 1'b0);
      chk("t1.cyc1_ready", req_ready, 1'b0);
      step();
      chk("t1.cyc2_valid", resp_valid, 1'b1);
      chk("t1.hit", resp_hit, 1'b0);
      chk("t1.way", resp_way, 2'd0);
      chk("t1.evict", resp_evict, 1'b0);
      chk("t1.tag", resp_tag, 8'h12);
      chk("t1.index", resp_index, 4'h3);
      chk("t1.bsel", resp_byte_select, 4'h4);
      step();
      chk("t1.pulse_end", resp_valid, 1'b0);
      chk("t1.hold_tag", resp_tag, 8'h12);
      lookup("t1.rehit", 16'h1234, 2'b00, 1'b1, 2'd0, 1'b0, 8'h00);

      // 2: fill a set, LRU hit, LRU victim
      do_reset();
      lookup("t2.r1", 16'h1234, 2'b00, 1'b0, 2'd0, 1'b0, 8'h00);
      lookup("t2.r2", 16'h2234, 2'b00, 1'b0, 2'd1, 1'b0, 8'h00);
      lookup("t2.r3", 16'h3234, 2'b00, 1'b0, 2'd2, 1'b0, 8'h00);
      lookup("t2.r4", 16'h4234, 2'b00, 1'b0, 2'd3, 1'b0, 8'h00);
      lookup("t2.hit1", 16'h1234, 2'b00, 1'b1, 2'd0, 1'b0, 8'h00);
      lookup("t2.r5", 16'h5234, 2'b00, 1'b0, 2'd1, 1'b0, 8'h00);

      // 3: dirty eviction
      do_reset();
      lookup("t3.wA", 16'hA050, 2'b01, 1'b0, 2'd0, 1'b0, 8'h00);
      lookup("t3.rB", 16'hB050, 2'b00, 1'b0, 2'd1, 1'b0, 8'h00);
      lookup("t3.rC", 16'hC050, 2'b00, 1'b0, 2'd2, 1'b0, 8'h00);
      lookup("t3.rD", 16'hD050, 2'b00, 1'b0, 2'd3, 1'b0, 8'h00);
      lookup("t3.rE", 16'hE050, 2'b00, 1'b0, 2'd0, 1'b1, 8'hA0);

      // 4: invalidate dirty hit, invalidate miss, re-read
      do_reset();
      lookup("t4.w", 16'h1234, 2'b01, 1'b0, 2'd0, 1'b0, 8'h00);
      lookup("t4.inv", 16'h1234, 2'b10, 1'b1, 2'd0, 1'b1, 8'h12);
      lookup("t4.inv2", 16'h1234, 2'b10, 1'b0, 2'd0, 1'b0, 8'h00);
      lookup("t4.r", 16'h1234, 2'b00, 1'b0, 2'd0, 1'b0, 8'h00);

      // 5: flush with ignored requests during the walk
      do_reset();
      lookup("t5.p1", 16'h1234, 2'b00, 1'b0, 2'd0, 1'b0, 8'h00);
      lookup("t5.p2", 16'h2234, 2'b01, 1'b0, 2'd1, 1'b0, 8'h00);
      lookup("t5.p3", 16'hA050, 2'b01, 1'b0, 2'd0, 1'b0, 8'h00);
      req_addr = 16'h5678; req_op = 2'b11; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("t5.busy_ready%0d", c), req_ready, 1'b0);
         chk($sformatf("t5.busy_valid%0d", c), resp_valid, 1'b0);
         req_valid = (c == 4 || c == 9);
         req_addr  = 16'h1234;
         req_op    = 2'b01;
         step();
      end
      req_valid = 1'b0;
      chk("t5.ready17", req_ready, 1'b0);
      chk("t5.valid17", resp_valid, 1'b1);
      chk("t5.hit", resp_hit, 1'b0);
      chk("t5.way", resp_way, 2'd0);
      chk("t5.evict", resp_evict, 1'b0);
      chk("t5.tag", resp_tag, 8'h56);
      chk("t5.index", resp_index, 4'h7);
      chk("t5.bsel", resp_byte_select, 4'h8);
      step();
      chk("t5.pulse_end", resp_valid, 1'b0);
      chk("t5.ready_back", req_ready, 1'b1);
      lookup("t5.r", 16'h1234, 2'b00, 1'b0, 2'd0, 1'b0, 8'h00);
      lookup("t5.rA", 16'hA050, 2'b00, 1'b0, 2'd0, 1'b0, 8'h00);

      // 6: reset during LOOKUP aborts and clears the array
      do_reset();
      lookup("t6.fill", 16'h1234, 2'b01, 1'b0, 2'd0, 1'b0, 8'h00);
      req_addr = 16'h1234; req_op = 2'b00; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      reset_n   = 1'b0;
      #1;
      chk("t6.rst_valid", resp_valid, 1'b0);
      chk("t6.rst_tag", resp_tag, 8'h00);
      chk("t6.rst_hit", resp_hit, 1'b0);
      step();
      chk("t6.rst_valid2", resp_valid, 1'b0);
      step();
      reset_n = 1'b1;
      step();
      chk("t6.no_resp", resp_valid, 1'b0);
      chk("t6.ready", req_ready, 1'b1);
      lookup("t6.r", 16'h1234, 2'b00, 1'b0, 2'd0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
